// File: rtl/aes_pkg.sv
// Shared AES types, S-box tables and byte-map helper for the SubBytes datapath.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sb_state_e;

  localparam byte_t SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte k of the column-major map (k = 4*col+row) sits at state[127-8k -: 8].
  function automatic int byte_lsb(input int k);
    return 8 * (15 - (k & 15));
  endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Handshake bundle for sub_bytes_iter; inv_mode only exists when SUB_BYTES_INV_EN is defined.
interface sub_bytes_iter_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_data;
  logic   out_valid;
  logic   out_ready;
  state_t out_data;
`ifdef SUB_BYTES_INV_EN
  logic   inv_mode;
`endif

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
`ifdef SUB_BYTES_INV_EN
    , output inv_mode
`endif
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
`ifdef SUB_BYTES_INV_EN
    , input inv_mode
`endif
  );

endinterface

// File: rtl/aes_sbox_lane.sv
// One combinational S-box lane; with SUB_BYTES_INV_EN defined it carries both tables and a select.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  byte_t in_byte,
`ifdef SUB_BYTES_INV_EN
  input  logic  inv_sel,
`endif
  output byte_t out_byte
);

`ifdef SUB_BYTES_INV_EN
  byte_t fwd_byte;
  byte_t inv_byte;

  assign fwd_byte = SBOX[in_byte];
  assign inv_byte = INV_SBOX[in_byte];
  assign out_byte = inv_sel ? inv_byte : fwd_byte;
`else
  assign out_byte = SBOX[in_byte];
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES shared S-box lanes walk the 16 state bytes in NPASS = 16/LANES cycles.
// Define SUB_BYTES_INV_EN to add the per-state inverse select (inv_mode, sampled on accept).
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            rst,
  sub_bytes_iter_if.slave bus
);

  localparam int NPASS = 16 / LANES;
  localparam int CNT_W = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(NPASS - 1);

  sb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           work_q, work_d;
  state_t           out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready;
  byte_t            lane_in  [LANES];
  byte_t            lane_out [LANES];
`ifdef SUB_BYTES_INV_EN
  logic             inv_q, inv_d;
`endif

  assign in_ready      = (state_q == IDLE) && !rst;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;

  // The current pass owns bytes cnt*LANES .. cnt*LANES+LANES-1, MSB-first.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = work_q[byte_lsb(int'(cnt_q) * LANES + l) +: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    aes_sbox_lane u_lane (
      .in_byte (lane_in[l]),
`ifdef SUB_BYTES_INV_EN
      .inv_sel (inv_q),
`endif
      .out_byte(lane_out[l])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
`ifdef SUB_BYTES_INV_EN
    inv_d   = inv_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          work_d  = bus.in_data;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef SUB_BYTES_INV_EN
          inv_d   = bus.inv_mode;
`endif
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[byte_lsb(int'(cnt_q) * LANES + l) +: 8] = lane_out[l];
        end
        // out_q is only loaded here so the consumer never sees a partly substituted state.
        if (cnt_q == LAST_PASS) begin
          cnt_d   = '0;
          state_d = DONE;
          out_d   = work_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef SUB_BYTES_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
`ifdef SUB_BYTES_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter with LANES = 1, 4 and 16 instances side by side.
// Latency is counted from the accept edge to the first edge at which the consumer sees out_valid.
module tb_sub_bytes_iter;
  import aes_pkg::*;

  localparam state_t FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam state_t FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam state_t ZEROS    = 128'h00000000000000000000000000000000;
  localparam state_t ALL63    = 128'h63636363636363636363636363636363;
  localparam state_t ONES     = 128'hffffffffffffffffffffffffffffffff;
  localparam state_t ALL16    = 128'h16161616161616161616161616161616;
  localparam state_t RST_IN   = 128'h53000000000000000000000000000000;
  localparam state_t RST_OUT  = 128'hed636363636363636363636363636363;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  sub_bytes_iter_if if1 ();
  sub_bytes_iter_if if4 ();
  sub_bytes_iter_if if16 ();

  sub_bytes_iter #(.LANES(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
  sub_bytes_iter #(.LANES(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));
  sub_bytes_iter #(.LANES(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  always #5 clk = ~clk;

  function automatic logic get_ready(input int which);
    case (which)
      1:       return if1.in_ready;
      16:      return if16.in_ready;
      default: return if4.in_ready;
    endcase
  endfunction

  function automatic logic get_valid(input int which);
    case (which)
      1:       return if1.out_valid;
      16:      return if16.out_valid;
      default: return if4.out_valid;
    endcase
  endfunction

  function automatic state_t get_data(input int which);
    case (which)
      1:       return if1.out_data;
      16:      return if16.out_data;
      default: return if4.out_data;
    endcase
  endfunction

  task automatic drive_in(input int which, input logic v, input state_t d);
    case (which)
      1:       begin if1.in_valid  = v; if1.in_data  = d; end
      16:      begin if16.in_valid = v; if16.in_data = d; end
      default: begin if4.in_valid  = v; if4.in_data  = d; end
    endcase
  endtask

  task automatic drive_out_ready(input int which, input logic r);
    case (which)
      1:       if1.out_ready  = r;
      16:      if16.out_ready = r;
      default: if4.out_ready  = r;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One transaction: wait for in_ready, accept, measure latency, capture out_data, optionally release.
  task automatic applyStimulus(input int which, input state_t data, input bit release_out,
                               output state_t result, output int latency, output int waited);
    logic seen;
    drive_out_ready(which, 1'b0);
    drive_in(which, 1'b1, data);
    waited = 0;
    while (!get_ready(which) && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    @(posedge clk);
    #1;
    drive_in(which, 1'b0, ZEROS);
    latency = 0;
    seen    = 1'b0;
    while (!seen && latency < 40) begin
      @(negedge clk);
      seen = get_valid(which);
      @(posedge clk);
      latency++;
    end
    #1;
    result = get_data(which);
    if (release_out) begin
      drive_out_ready(which, 1'b1);
      @(posedge clk);
      #1;
      drive_out_ready(which, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    state_t res;
    int     lat;
    int     wt;
    logic   any_valid;

    rst = 1'b1;
    drive_in(1, 1'b1, FIPS_IN);
    drive_in(4, 1'b1, FIPS_IN);
    drive_in(16, 1'b1, FIPS_IN);
    drive_out_ready(1, 1'b0);
    drive_out_ready(4, 1'b0);
    drive_out_ready(16, 1'b0);
`ifdef SUB_BYTES_INV_EN
    if1.inv_mode  = 1'b0;
    if4.inv_mode  = 1'b0;
    if16.inv_mode = 1'b0;
`endif

    // Reset held three edges with in_valid high.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 128'(if4.out_valid), 128'(0));
    checkOutput("rst_out_data", if4.out_data, ZEROS);
    checkOutput("rst_in_ready_l4", 128'(if4.in_ready), 128'(0));
    checkOutput("rst_in_ready_l1", 128'(if1.in_ready), 128'(0));
    checkOutput("rst_in_ready_l16", 128'(if16.in_ready), 128'(0));
    rst = 1'b0;
    drive_in(1, 1'b0, ZEROS);
    drive_in(4, 1'b0, ZEROS);
    drive_in(16, 1'b0, ZEROS);
    #1;
    checkOutput("post_rst_in_ready", 128'(if4.in_ready), 128'(1));
    @(posedge clk);
    #1;

    applyStimulus(4, FIPS_IN, 1'b1, res, lat, wt);
    checkOutput("fips_l4_data", res, FIPS_OUT);
    checkOutput("fips_l4_latency", 128'(lat), 128'(5));
    checkOutput("fips_l4_wait", 128'(wt), 128'(0));

    applyStimulus(1, ZEROS, 1'b1, res, lat, wt);
    checkOutput("zeros_l1_data", res, ALL63);
    checkOutput("zeros_l1_latency", 128'(lat), 128'(17));
    applyStimulus(1, ONES, 1'b1, res, lat, wt);
    checkOutput("ones_l1_data", res, ALL16);
    checkOutput("ones_l1_latency", 128'(lat), 128'(17));

    applyStimulus(16, ZEROS, 1'b1, res, lat, wt);
    checkOutput("zeros_l16_data", res, ALL63);
    checkOutput("zeros_l16_latency", 128'(lat), 128'(2));
    applyStimulus(16, ONES, 1'b1, res, lat, wt);
    checkOutput("ones_l16_data", res, ALL16);
    checkOutput("ones_l16_latency", 128'(lat), 128'(2));

    // Backpressure: hold DONE for ten cycles, then release for one.
    applyStimulus(4, FIPS_IN, 1'b0, res, lat, wt);
    checkOutput("bp_data", res, FIPS_OUT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_data", if4.out_data, FIPS_OUT);
      checkOutput("bp_hold_valid", 128'(if4.out_valid), 128'(1));
      checkOutput("bp_hold_in_ready", 128'(if4.in_ready), 128'(0));
    end
    if4.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if4.out_ready = 1'b0;
    checkOutput("bp_release_in_ready", 128'(if4.in_ready), 128'(1));
    checkOutput("bp_release_valid", 128'(if4.out_valid), 128'(0));
    checkOutput("bp_release_data", if4.out_data, FIPS_OUT);
    applyStimulus(4, ONES, 1'b1, res, lat, wt);
    checkOutput("bp_next_wait", 128'(wt), 128'(0));
    checkOutput("bp_next_data", res, ALL16);
    checkOutput("bp_next_latency", 128'(lat), 128'(5));

    // Reset asserted during the second BUSY cycle.
    drive_in(4, 1'b1, FIPS_IN);
    checkOutput("mid_rst_pre_ready", 128'(if4.in_ready), 128'(1));
    @(posedge clk);
    #1;
    drive_in(4, 1'b0, ZEROS);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready_low", 128'(if4.in_ready), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", 128'(if4.in_ready), 128'(1));
    checkOutput("mid_rst_out_data", if4.out_data, ZEROS);
    any_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      any_valid = any_valid | if4.out_valid;
    end
    checkOutput("mid_rst_no_output", 128'(any_valid), 128'(0));
    @(posedge clk);
    #1;
    applyStimulus(4, RST_IN, 1'b1, res, lat, wt);
    checkOutput("mid_rst_next_data", res, RST_OUT);
    checkOutput("mid_rst_next_latency", 128'(lat), 128'(5));

`ifdef SUB_BYTES_INV_EN
    if4.inv_mode = 1'b1;
    applyStimulus(4, FIPS_OUT, 1'b1, res, lat, wt);
    checkOutput("inv_fips_data", res, FIPS_IN);
    checkOutput("inv_fips_latency", 128'(lat), 128'(5));
    if4.inv_mode = 1'b0;
    applyStimulus(4, ZEROS, 1'b1, res, lat, wt);
    checkOutput("mix_fwd1_data", res, ALL63);
    if4.inv_mode = 1'b1;
    applyStimulus(4, ALL63, 1'b1, res, lat, wt);
    checkOutput("mix_inv_data", res, ZEROS);
    if4.inv_mode = 1'b0;
    applyStimulus(4, ONES, 1'b1, res, lat, wt);
    checkOutput("mix_fwd2_data", res, ALL16);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
